// File: rtl/mtc2sl_pkg.sv
// Shared l0mdt constants and types for the MTC2SL collector.
// The valid flag is the word's MSB.
package mtc2sl_pkg;
    localparam int MTC2SL_LEN = 193;
    localparam int VALID_BIT  = MTC2SL_LEN - 1;
    localparam int N_CH       = 3;
    localparam int CH_W       = 2;

    typedef logic [MTC2SL_LEN-1:0] mtc2sl_t;
    typedef logic [CH_W-1:0]       ch_idx_t;
    typedef enum logic {ST_EMPTY, ST_HOLD} out_state_t;
endpackage

// File: rtl/mtc2sl_chan_fifo.sv
// Per-channel synchronous FIFO with a saturating drop counter.
// Head data is read combinationally from the array.
module mtc2sl_chan_fifo #(
    parameter int WIDTH     = 193,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     head,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic [CNT_WIDTH-1:0] drop_reg;
    logic                 wr_ok;
    logic                 rd_ok;

    // Fullness uses pre-edge occupancy, so a write to a full FIFO drops even if it pops.
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign head  = mem[rd_ptr_reg];
    assign drop_cnt = drop_reg;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (wr_en && full && (drop_reg != '1)) begin
                drop_reg <= drop_reg + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/mtc2sl_collector.sv
// Collects three MTC2SL candidate buses into per-channel FIFOs and
// round-robin serializes them onto a single valid/ready stream.
module mtc2sl_collector
    import mtc2sl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [MTC2SL_LEN-1:0]     mtc0,
    input  logic [MTC2SL_LEN-1:0]     mtc1,
    input  logic [MTC2SL_LEN-1:0]     mtc2,
    output logic [MTC2SL_LEN-1:0]     out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH-1:0]           fifo_full,
    output logic [N_CH*CNT_WIDTH-1:0] drop_cnt
);
    mtc2sl_t    mtc_in [N_CH];
    mtc2sl_t    head [N_CH];
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] rd_en;

    out_state_t state_reg;
    ch_idx_t    last_grant_reg;
    mtc2sl_t    out_data_reg;
    ch_idx_t    out_ch_reg;
    logic       out_valid_reg;

    logic       pop_ok;
    logic       grant_any;
    ch_idx_t    grant_sel;
    int         idx;

    assign mtc_in[0] = mtc0;
    assign mtc_in[1] = mtc1;
    assign mtc_in[2] = mtc2;

    assign pop_ok = (state_reg == ST_EMPTY) || out_ready;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rd_en[gi] = pop_ok && grant_any && (grant_sel == ch_idx_t'(gi));

            mtc2sl_chan_fifo #(
                .WIDTH     (MTC2SL_LEN),
                .DEPTH     (FIFO_DEPTH),
                .CNT_WIDTH (CNT_WIDTH)
            ) u_fifo (
                .clk      (clock),
                .srst     (rst),
                .wr_en    (mtc_in[gi][VALID_BIT]),
                .wr_data  (mtc_in[gi]),
                .rd_en    (rd_en[gi]),
                .head     (head[gi]),
                .empty    (empty[gi]),
                .full     (fifo_full[gi]),
                .drop_cnt (drop_cnt[gi*CNT_WIDTH +: CNT_WIDTH])
            );
        end
    endgenerate

    // Scan downward so the closest channel after last_grant wins.
    always_comb begin
        grant_sel = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = (int'(last_grant_reg) + k) % N_CH;
            if (!empty[idx]) begin
                grant_sel = ch_idx_t'(idx);
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg      <= ST_EMPTY;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
            last_grant_reg <= ch_idx_t'(N_CH - 1);
        end else if (pop_ok) begin
            if (grant_any) begin
                state_reg      <= ST_HOLD;
                out_valid_reg  <= 1'b1;
                out_data_reg   <= head[grant_sel];
                out_ch_reg     <= grant_sel;
                last_grant_reg <= grant_sel;
            end else begin
                state_reg     <= ST_EMPTY;
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_mtc2sl_collector.sv
// Randomized and directed checks of mtc2sl_collector against a queue-based model.
// A second instance with 4-bit drop counters shares the inputs to exercise saturation.
module tb_mtc2sl_collector;
    localparam int DEPTH = 4;
    typedef logic [192:0] word_t;

    logic  clock = 1'b0;
    logic  rst = 1'b1;
    logic  out_ready = 1'b0;
    word_t mtc [3];

    word_t       out_data, out_data_s;
    logic [1:0]  out_ch, out_ch_s;
    logic        out_valid, out_valid_s;
    logic [2:0]  fifo_full, fifo_full_s;
    logic [47:0] drop_cnt;
    logic [11:0] drop_cnt_s;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model state
    word_t   mq [3][$];
    logic    m_valid;
    word_t   m_data;
    int      m_ch;
    int      m_last;
    longint  m_drop [3];

    mtc2sl_collector #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clock(clock), .rst(rst), .mtc0(mtc[0]), .mtc1(mtc[1]), .mtc2(mtc[2]),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_full(fifo_full), .drop_cnt(drop_cnt));

    mtc2sl_collector #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut_s (
        .clock(clock), .rst(rst), .mtc0(mtc[0]), .mtc1(mtc[1]), .mtc2(mtc[2]),
        .out_data(out_data_s), .out_ch(out_ch_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .fifo_full(fifo_full_s), .drop_cnt(drop_cnt_s));

    initial forever #5 clock = ~clock;

    function automatic word_t mk(bit flag, logic [31:0] payload);
        word_t w;
        w = '0;
        w[31:0] = payload;
        w[192] = flag;
        return w;
    endfunction

    function automatic word_t rand_word(bit flag);
        word_t w;
        w = {flag, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w;
    endfunction

    function automatic longint sat(longint d, longint mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [2:0] m_full();
        logic [2:0] f;
        for (int c = 0; c < 3; c++) f[c] = (mq[c].size() == DEPTH);
        return f;
    endfunction

    // One clock edge of the specified behaviour, from pre-edge inputs.
    task automatic model_edge();
        bit full_pre [3];
        int found;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                mq[c].delete();
                m_drop[c] = 0;
            end
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = 2;
        end else begin
            for (int c = 0; c < 3; c++) full_pre[c] = (mq[c].size() == DEPTH);
            if (!m_valid || out_ready) begin
                found = -1;
                for (int k = 1; k <= 3; k++) begin
                    if (found < 0 && mq[(m_last + k) % 3].size() > 0) found = (m_last + k) % 3;
                end
                if (found >= 0) begin
                    m_data = mq[found].pop_front();
                    m_ch = found; m_last = found; m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (mtc[c][192]) begin
                    if (full_pre[c]) m_drop[c]++;
                    else mq[c].push_back(mtc[c]);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 3; c++) mtc[c] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got=%0d want=0", out_ch); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h want=0", out_data); end
        n_cmp++; if (fifo_full !== 3'b000) begin n_fail++; $display("FAIL reset_full got=%b want=000", fifo_full); end
        n_cmp++; if (drop_cnt !== 48'd0 || drop_cnt_s !== 12'd0) begin n_fail++; $display("FAIL reset_drop got=%h/%h want=0", drop_cnt, drop_cnt_s); end
        $display("reset: out_valid=%b fifo_full=%b drop_cnt=%h", out_valid, fifo_full, drop_cnt);
    endtask

    task automatic test_single_word();
        word_t w;
        out_ready = 1'b1;
        w = mk(1'b1, 32'h1A5);
        mtc[1] = w;
        step();
        clear_inputs();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_capture_valid got=%b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b want=1", out_valid); end
        n_cmp++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL single_ch got=%0d want=1", out_ch); end
        n_cmp++; if (out_data !== w) begin n_fail++; $display("FAIL single_data got=%h want=%h", out_data, w); end
        $display("single: ch=%0d data=%h", out_ch, out_data);
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after got=%b want=0", out_valid); end
    endtask

    task automatic test_round_robin();
        word_t w [3];
        int exp_order [3];
        do_reset();
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 3; c++) begin
                w[c] = mk(1'b1, 32'h100 * (pass + 1) + c);
                mtc[c] = w[c];
                exp_order[c] = (pass == 0) ? c : (c + 1) % 3;
            end
            step();
            clear_inputs();
            for (int i = 0; i < 3; i++) begin
                step();
                n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'(exp_order[i]) || out_data !== w[exp_order[i]])
                    begin n_fail++; $display("FAIL rr_order pass=%0d slot=%0d got v=%b ch=%0d want ch=%0d", pass, i, out_valid, out_ch, exp_order[i]); end
                $display("round_robin: pass=%0d slot=%0d ch=%0d", pass, i, out_ch);
            end
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b want=0", out_valid); end
            if (pass == 0) begin
                // Partial burst on ch0 leaves last_grant=0.
                mtc[0] = mk(1'b1, 32'h55);
                step();
                clear_inputs();
                step();
                n_cmp++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_partial got ch=%0d v=%b want ch=0 v=1", out_ch, out_valid); end
                step();
            end
        end
    endtask

    task automatic test_backpressure();
        word_t w [3];
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = mk(1'b1, 32'hB000 + i);
            mtc[0] = w[i];
            step();
        end
        clear_inputs();
        for (int i = 0; i < 7; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== w[0] || fifo_full[0] !== 1'b0)
                begin n_fail++; $display("FAIL bp_stall cyc=%0d got v=%b data=%h full=%b want v=1 data=%h full=0", i, out_valid, out_data, fifo_full[0], w[0]); end
            step();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== w[i]) begin n_fail++; $display("FAIL bp_release idx=%0d got %h want %h", i, out_data, w[i]); end
            $display("backpressure: delivered word %0d data=%h", i, out_data);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_overflow();
        word_t w [7];
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            w[i] = mk(1'b1, 32'hC000 + i);
            mtc[2] = w[i];
            step();
        end
        clear_inputs();
        n_cmp++; if (fifo_full[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b want=1", fifo_full[2]); end
        n_cmp++; if (drop_cnt[47:32] !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got=%0d want=2", drop_cnt[47:32]); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== w[0]) begin n_fail++; $display("FAIL ovf_held got %h want %h", out_data, w[0]); end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== w[i]) begin n_fail++; $display("FAIL ovf_order idx=%0d got %h want %h", i, out_data, w[i]); end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0 || fifo_full[2] !== 1'b0) begin n_fail++; $display("FAIL ovf_end got v=%b full=%b want 0/0", out_valid, fifo_full[2]); end
        $display("overflow: drop_cnt[2]=%0d", drop_cnt[47:32]);
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            mtc[0] = rand_word(1'b1);
            step();
        end
        clear_inputs();
        n_cmp++; if (drop_cnt_s[3:0] !== 4'd15) begin n_fail++; $display("FAIL sat_drop4 got=%0d want=15", drop_cnt_s[3:0]); end
        n_cmp++; if (drop_cnt[15:0] !== 16'd20) begin n_fail++; $display("FAIL sat_drop16 got=%0d want=20", drop_cnt[15:0]); end
        n_cmp++; if (fifo_full[0] !== 1'b1) begin n_fail++; $display("FAIL sat_full got=%b want=1", fifo_full[0]); end
        $display("saturation: drop4=%0d drop16=%0d", drop_cnt_s[3:0], drop_cnt[15:0]);
    endtask

    task automatic test_reset_mid();
        word_t a, b;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mtc[1] = (i < 3) ? mk(1'b1, 32'hD000 + i) : '0;
            mtc[2] = mk(1'b1, 32'hE000 + i);
            step();
        end
        clear_inputs();
        n_cmp++; if (out_valid !== 1'b1 || drop_cnt[47:32] !== 16'(m_drop[2])) begin n_fail++; $display("FAIL rmid_pre got v=%b drop=%0d want v=1 drop=%0d", out_valid, drop_cnt[47:32], m_drop[2]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || drop_cnt !== 48'd0 || fifo_full !== 3'b000) begin n_fail++; $display("FAIL rmid_reset got v=%b drop=%h full=%b want 0", out_valid, drop_cnt, fifo_full); end
        out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_leftover got=%b want=0", out_valid); end
        a = mk(1'b1, 32'hA2); b = mk(1'b1, 32'hA0);
        mtc[2] = a; mtc[0] = b;
        step();
        clear_inputs();
        step();
        n_cmp++; if (out_ch !== 2'd0 || out_data !== b) begin n_fail++; $display("FAIL rmid_first got ch=%0d want 0", out_ch); end
        step();
        n_cmp++; if (out_ch !== 2'd2 || out_data !== a) begin n_fail++; $display("FAIL rmid_second got ch=%0d want 2", out_ch); end
        $display("reset_mid: post-reset order ch0 then ch%0d", out_ch);
        step();
    endtask

    task automatic test_random();
        int ready_pct;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            ready_pct = (cyc < 400) ? 75 : 30;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            for (int c = 0; c < 3; c++) mtc[c] = rand_word($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            step();
            rst = 1'b0;
            n_cmp++; if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_ch !== 2'(m_ch))))
                begin n_fail++; $display("FAIL rand_out cyc=%0d got v=%b ch=%0d data=%h want v=%b ch=%0d data=%h", cyc, out_valid, out_ch, out_data, m_valid, m_ch, m_data); end
            n_cmp++; if (fifo_full !== m_full() || fifo_full_s !== m_full()) begin n_fail++; $display("FAIL rand_full cyc=%0d got %b/%b want %b", cyc, fifo_full, fifo_full_s, m_full()); end
            for (int c = 0; c < 3; c++) begin
                n_cmp++; if (drop_cnt[c*16 +: 16] !== 16'(sat(m_drop[c], 65535)) || drop_cnt_s[c*4 +: 4] !== 4'(sat(m_drop[c], 15)))
                    begin n_fail++; $display("FAIL rand_drop cyc=%0d ch=%0d got %0d/%0d want %0d", cyc, c, drop_cnt[c*16 +: 16], drop_cnt_s[c*4 +: 4], m_drop[c]); end
            end
            n_cmp++; if (out_valid_s !== m_valid) begin n_fail++; $display("FAIL rand_valid_s cyc=%0d got %b want %b", cyc, out_valid_s, m_valid); end
            if (cyc % 100 == 99) $display("random: cyc=%0d v=%b ch=%0d drops=%0d,%0d,%0d", cyc, out_valid, out_ch, m_drop[0], m_drop[1], m_drop[2]);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mtc2sl_collector.md
Name: mtc2sl_collector

Overview:
- Downstream receiving end of the three parallel MTC2SL candidate buses produced by the MTC builder.
- Captures each valid candidate into a per-channel FIFO, then round-robin serializes them onto one valid/ready stream toward the sector-logic link packer.
- Counts candidates dropped on FIFO overflow, per channel.

Parameters:
- MTC2SL_LEN, 193, width of one MTC2SL word; bit MTC2SL_LEN-1 is its data_valid flag.
- N_CH, 3, number of input channels (equals n_PRIMARY_MTC).
- FIFO_DEPTH, 4, entries per channel FIFO; power of 2, at least 2.
- CNT_WIDTH, 16, width of each drop counter.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mtc0  in  MTC2SL_LEN  channel 0 word; sampled every cycle.
- mtc1  in  MTC2SL_LEN  channel 1 word.
- mtc2  in  MTC2SL_LEN  channel 2 word.
- out_data  out  MTC2SL_LEN  serialized word, data_valid bit passed through unchanged.
- out_ch  out  2  source channel of out_data.
- out_valid  out  1  out_data/out_ch hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- fifo_full  out  N_CH  per-channel FIFO full flag (count==FIFO_DEPTH).
- drop_cnt  out  N_CH*CNT_WIDTH  per-channel saturating drop counters; ch0 occupies the LSBs.

Behaviour:
- Reset (rst=1 at a clock edge): all FIFOs empty; out_valid=0, out_data=0, out_ch=0, fifo_full=0, drop_cnt=0; last_grant=N_CH-1, so ch0 has first priority. A reset asserted mid-operation discards all buffered and held words.
- Capture: in any cycle where mtcN[MTC2SL_LEN-1]=1, the whole word is written to FIFO N. Words with the flag at 0 are ignored.
- Overflow: full is evaluated on the occupancy before any same-cycle pop. A write to a full FIFO is dropped, drop_cnt[N] increments, and the FIFO is unchanged. The counter saturates at 2^CNT_WIDTH-1. Simultaneous drops on several channels each increment their own counter.
- Output stage, two states:
  - EMPTY (out_valid=0).
  - HOLD (out_valid=1).
- Pop condition: pop allowed when state EMPTY, or when HOLD and out_ready=1.
- On pop: the arbiter selects the first non-empty FIFO searching from last_grant+1 with wrap-around modulo N_CH. Its head loads out_data/out_ch, state becomes HOLD, and last_grant is set to the selected channel.
- If pop is allowed and all FIFOs are empty: out_valid falls to 0 next cycle, or stays 0.
- HOLD with out_ready=0: out_data/out_ch/out_valid stable, no pop, last_grant unchanged.
- Throughput: one word per cycle when out_ready is held high; no bubble between back-to-back words.
- Latency: a word captured at edge t (FIFO empty, stage EMPTY, no competing channel) appears with out_valid=1 after edge t+1, i.e. 1 cycle after capture.
- A same-cycle write and pop on the same FIFO are both performed, and occupancy is unchanged.
- A write never bypasses the FIFO; the arbiter sees only pre-edge occupancy.
- out_valid is never asserted while out_data's valid bit is 0.

Decomposition:
- Shared package (l0mdt constants): MTC2SL_LEN, the data_valid bit index, and N_CH as constants; a typed mtc2sl word alias; the channel-index type.
- One sub-module, mtc2sl_chan_fifo:
  - Synchronous FIFO with wr_en, rd_en, head data, empty, full, and drop-counter logic.
  - Width and depth set by parameters.
  - Instantiated N_CH times.
- Round-robin arbiter and output register stay in the top level.

Test Plan:
- Single word: ch1 word with flag=1 and payload 0x1A5 for 1 cycle, out_ready=1 → one cycle later out_valid=1, out_ch=1, out_data equals the input; the next cycle out_valid=0.
- Round-robin: ch0, ch1 and ch2 each valid with a distinct payload in the same cycle, out_ready=1 → out_ch sequence 0,1,2 on consecutive cycles. Repeat from idle → the order starts at 0 again only if last_grant=2; after a partial burst the rotation continues from last_grant+1.
- Backpressure: out_ready=0 for 10 cycles while ch0 sends 3 words → out_data constant through the stall and fifo_full[0]=0; releasing out_ready → all 3 words delivered in order with no loss.
- Overflow: out_ready=0, ch2 sends 7 consecutive valid words → fifo_full[2]=1, drop_cnt[2]=7-(FIFO_DEPTH+1)=2 (the held word plus 4 buffered); then out_ready=1 → exactly 5 words emerge, in order.
- Saturation: CNT_WIDTH=4, force 20 drops on ch0 → drop_cnt[0] stops at 15.
- Reset mid-operation: assert rst for 1 cycle with 2 words buffered and out_valid=1 → next cycle out_valid=0 and all counters 0; words arriving afterwards are delivered normally, with ch0 first.
